// File: rtl/axi4_lite_sif.sv
// AXI4-Lite slave that bridges single-beat AXI transactions onto a simple
// register bus. The write and read channels are independent FSMs that can be
// busy at the same time. Every output is driven directly from a flop.
module axi4_lite_sif #(
  parameter logic [15:0] RD_TIMEOUT = 16'd255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic        REG_WREN,
  output logic [15:0] REG_WADR,
  output logic [31:0] REG_WDAT,
  output logic        REG_RDEN,
  output logic [15:0] REG_RADR,
  input  logic [31:0] REG_RDAT,
  input  logic        REG_RVLD
);

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP}          w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP}  r_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // ---------------------------------------------------------------- write side
  w_state_t    w_state, w_state_nxt;
  logic        aw_got, aw_got_nxt;
  logic        w_got, w_got_nxt;
  logic [31:0] aw_addr, aw_addr_nxt;
  logic [31:0] w_data, w_data_nxt;
  logic [3:0]  w_strb, w_strb_nxt;
  logic        wr_ok, wr_ok_nxt;
  logic        awready_nxt, wready_nxt, bvalid_nxt, wren_nxt;
  logic [1:0]  bresp_nxt;
  logic [15:0] wadr_nxt;
  logic [31:0] wdat_nxt;

  // Write FSM: collect AW and W in any order, issue one strobe, then respond.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    w_state_nxt = w_state;
    aw_got_nxt  = aw_got;
    w_got_nxt   = w_got;
    aw_addr_nxt = aw_addr;
    w_data_nxt  = w_data;
    w_strb_nxt  = w_strb;
    wr_ok_nxt   = wr_ok;
    awready_nxt = 1'b0;
    wready_nxt  = 1'b0;
    bvalid_nxt  = S_AXI_BVALID;
    bresp_nxt   = S_AXI_BRESP;
    wren_nxt    = 1'b0;
    wadr_nxt    = REG_WADR;
    wdat_nxt    = REG_WDAT;
    case (w_state)
      W_IDLE: begin
        if (S_AXI_AWVALID && S_AXI_AWREADY) begin
          aw_got_nxt  = 1'b1;
          aw_addr_nxt = S_AXI_AWADDR;
        end
        if (S_AXI_WVALID && S_AXI_WREADY) begin
          w_got_nxt  = 1'b1;
          w_data_nxt = S_AXI_WDATA;
          w_strb_nxt = S_AXI_WSTRB;
        end
        // Each READY stays up only until its own beat has been taken.
        awready_nxt = !aw_got_nxt;
        wready_nxt  = !w_got_nxt;
        if (aw_got_nxt && w_got_nxt) begin
          // Decide legality here so the strobe lines up with the W_ISSUE cycle.
          w_state_nxt = W_ISSUE;
          wr_ok_nxt   = (aw_addr_nxt[31:16] == 16'h0) && (w_strb_nxt == 4'hF);
          wren_nxt    = wr_ok_nxt;
          if (wr_ok_nxt) begin
            wadr_nxt = aw_addr_nxt[15:0];
            wdat_nxt = w_data_nxt;
          end
        end
      end
      W_ISSUE: begin
        w_state_nxt = W_RESP;
        bvalid_nxt  = 1'b1;
        bresp_nxt   = wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          w_state_nxt = W_IDLE;
          bvalid_nxt  = 1'b0;
          aw_got_nxt  = 1'b0;
          w_got_nxt   = 1'b0;
          awready_nxt = 1'b1;
          wready_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write state and registered write-side outputs.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!RST_N) begin
      w_state       <= W_IDLE;
      aw_got        <= 1'b0;
      w_got         <= 1'b0;
      aw_addr       <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      wr_ok         <= 1'b0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      REG_WREN      <= 1'b0;
      REG_WADR      <= '0;
      REG_WDAT      <= '0;
    end else begin
      w_state       <= w_state_nxt;
      aw_got        <= aw_got_nxt;
      w_got         <= w_got_nxt;
      aw_addr       <= aw_addr_nxt;
      w_data        <= w_data_nxt;
      w_strb        <= w_strb_nxt;
      wr_ok         <= wr_ok_nxt;
      S_AXI_AWREADY <= awready_nxt;
      S_AXI_WREADY  <= wready_nxt;
      S_AXI_BVALID  <= bvalid_nxt;
      S_AXI_BRESP   <= bresp_nxt;
      REG_WREN      <= wren_nxt;
      REG_WADR      <= wadr_nxt;
      REG_WDAT      <= wdat_nxt;
    end
  end

  // ----------------------------------------------------------------- read side
  r_state_t    r_state, r_state_nxt;
  logic        ar_ok, ar_ok_nxt;
  logic [15:0] cnt, cnt_nxt, cnt_inc;
  logic        arready_nxt, rden_nxt, rvalid_nxt;
  logic [15:0] radr_nxt;
  logic [31:0] rdata_nxt;
  logic [1:0]  rresp_nxt;

  assign cnt_inc = cnt + 16'd1;

  // Read FSM: strobe the register bus, wait for data or time out, then respond.
  always_comb begin
    r_state_nxt = r_state;
    ar_ok_nxt   = ar_ok;
    cnt_nxt     = cnt;
    arready_nxt = 1'b0;
    rden_nxt    = 1'b0;
    radr_nxt    = REG_RADR;
    rvalid_nxt  = S_AXI_RVALID;
    rdata_nxt   = S_AXI_RDATA;
    rresp_nxt   = S_AXI_RRESP;
    case (r_state)
      R_IDLE: begin
        arready_nxt = 1'b1;
        if (S_AXI_ARVALID && S_AXI_ARREADY) begin
          r_state_nxt = R_ISSUE;
          arready_nxt = 1'b0;
          ar_ok_nxt   = (S_AXI_ARADDR[31:16] == 16'h0);
          rden_nxt    = ar_ok_nxt;
          if (ar_ok_nxt) begin
            radr_nxt = S_AXI_ARADDR[15:0];
          end
        end
      end
      R_ISSUE: begin
        if (ar_ok) begin
          r_state_nxt = R_WAIT;
          cnt_nxt     = '0;
        end else begin
          r_state_nxt = R_RESP;
          rvalid_nxt  = 1'b1;
          rdata_nxt   = '0;
          rresp_nxt   = RESP_SLVERR;
        end
      end
      R_WAIT: begin
        // Data arriving in the last allowed wait cycle still wins over the timeout.
        if (REG_RVLD) begin
          r_state_nxt = R_RESP;
          rvalid_nxt  = 1'b1;
          rdata_nxt   = REG_RDAT;
          rresp_nxt   = RESP_OKAY;
        end else if (cnt_inc == RD_TIMEOUT) begin
          r_state_nxt = R_RESP;
          rvalid_nxt  = 1'b1;
          rdata_nxt   = '0;
          rresp_nxt   = RESP_SLVERR;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          r_state_nxt = R_IDLE;
          rvalid_nxt  = 1'b0;
          arready_nxt = 1'b1;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read state and registered read-side outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state       <= R_IDLE;
      ar_ok         <= 1'b0;
      cnt           <= '0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
      REG_RDEN      <= 1'b0;
      REG_RADR      <= '0;
    end else begin
      r_state       <= r_state_nxt;
      ar_ok         <= ar_ok_nxt;
      cnt           <= cnt_nxt;
      S_AXI_ARREADY <= arready_nxt;
      S_AXI_RVALID  <= rvalid_nxt;
      S_AXI_RDATA   <= rdata_nxt;
      S_AXI_RRESP   <= rresp_nxt;
      REG_RDEN      <= rden_nxt;
      REG_RADR      <= radr_nxt;
    end
  end

endmodule

// File: tb/tb_axi4_lite_sif.sv
// Self-checking bench for axi4_lite_sif: directed corner cases followed by
// randomized write/read/concurrent transactions, all checked against a
// transaction-level model of the bridge.
module tb_axi4_lite_sif;

  localparam int RD_TO = 8;

  logic        CLK;
  logic        RST_N;
  logic [31:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        REG_WREN;
  logic [15:0] REG_WADR;
  logic [31:0] REG_WDAT;
  logic        REG_RDEN;
  logic [15:0] REG_RADR;
  logic [31:0] REG_RDAT;
  logic        REG_RVLD;

  axi4_lite_sif #(.RD_TIMEOUT(16'(RD_TO))) dut (
    .CLK(CLK), .RST_N(RST_N),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .REG_WREN(REG_WREN), .REG_WADR(REG_WADR), .REG_WDAT(REG_WDAT),
    .REG_RDEN(REG_RDEN), .REG_RADR(REG_RADR), .REG_RDAT(REG_RDAT), .REG_RVLD(REG_RVLD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [106:0] all_outs();
    return {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
            S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, REG_WREN, REG_WADR, REG_WDAT,
            REG_RDEN, REG_RADR};
  endfunction

  // Register-bus observers: every cycle with a strobe high is logged.
  typedef struct { logic [15:0] adr; logic [31:0] dat; int at; } bus_ev_t;
  bus_ev_t wr_q[$];
  bus_ev_t rd_q[$];

  initial forever begin
    @(posedge CLK); #1;
    if (REG_WREN === 1'b1) wr_q.push_back('{REG_WADR, REG_WDAT, cyc});
  end

  // Register-file responder: answers a read strobe with REG_RVLD rsp_delay
  // cycles later (0 = never answers).
  int          rsp_delay = 0;
  logic [31:0] rsp_data  = '0;
  bit          rsp_busy  = 1'b0;

  initial begin
    REG_RVLD = 1'b0;
    REG_RDAT = 32'h0BAD_F00D;
    forever begin
      @(posedge CLK); #1;
      if (REG_RDEN === 1'b1) begin
        rd_q.push_back('{REG_RADR, 32'h0, cyc});
        if (rsp_delay > 0) begin
          rsp_busy = 1'b1;
          repeat (rsp_delay) @(posedge CLK);
          #1;
          REG_RVLD = 1'b1;
          REG_RDAT = rsp_data;
          @(posedge CLK); #1;
          REG_RVLD = 1'b0;
          REG_RDAT = $urandom;
          rsp_busy = 1'b0;
        end
      end
    end
  end

  // One write: AW after aw_dly cycles, W after w_dly cycles, BREADY held low
  // for b_dly cycles once BVALID is up.
  task automatic wr_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input int aw_dly, input int w_dly, input int b_dly);
    bit         aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs;
    bit         rdy_bad = 1'b0, hold_bad = 1'b0;
    bit         legal;
    int         t = 0, hs_cyc = 0;
    logic [1:0] exp_resp, resp0;
    legal    = (addr[31:16] == 16'h0) && (strb == 4'hF);
    exp_resp = legal ? 2'b00 : 2'b10;
    wr_q.delete();
    S_AXI_BREADY = 1'b0;
    while (!(aw_done && w_done) && t < 50) begin
      S_AXI_AWVALID = !aw_done && (t >= aw_dly);
      S_AXI_AWADDR  = S_AXI_AWVALID ? addr : $urandom;
      S_AXI_WVALID  = !w_done && (t >= w_dly);
      S_AXI_WDATA   = S_AXI_WVALID ? data : $urandom;
      S_AXI_WSTRB   = S_AXI_WVALID ? strb : 4'($urandom);
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge CLK); #1;
      aw_done |= aw_hs;
      w_done  |= w_hs;
      if (aw_done && w_done) hs_cyc = cyc;
      if ((aw_done && S_AXI_AWREADY) || (w_done && S_AXI_WREADY)) rdy_bad = 1'b1;
      t++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_AWADDR  = $urandom;
    S_AXI_WDATA   = $urandom;
    check("wr_handshake", 128'(aw_done && w_done), 128'(1));
    if (!(aw_done && w_done)) return;
    t = 0;
    while (S_AXI_BVALID !== 1'b1 && t < 20) begin
      if (S_AXI_AWREADY || S_AXI_WREADY) rdy_bad = 1'b1;
      @(posedge CLK); #1;
      t++;
    end
    check("wr_bvalid_seen", 128'(S_AXI_BVALID), 128'(1));
    check("wr_b_latency", 128'(cyc - hs_cyc), 128'(1));
    check("wr_bresp", 128'(S_AXI_BRESP), 128'(exp_resp));
    resp0 = S_AXI_BRESP;
    repeat (b_dly) begin
      @(posedge CLK); #1;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== resp0) hold_bad = 1'b1;
      if (S_AXI_AWREADY || S_AXI_WREADY) rdy_bad = 1'b1;
    end
    S_AXI_BREADY = 1'b1;
    @(posedge CLK); #1;
    S_AXI_BREADY = 1'b0;
    check("wr_b_hold", 128'(hold_bad), 128'(0));
    check("wr_ready_low", 128'(rdy_bad), 128'(0));
    check("wr_ready_back", 128'({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}), 128'(3'b011));
    check("wr_wren_count", 128'(wr_q.size()), 128'(legal));
    if (legal && wr_q.size() > 0) begin
      check("wr_wren_payload", 128'({wr_q[0].adr, wr_q[0].dat}), 128'({addr[15:0], data}));
      check("wr_wren_latency", 128'(wr_q[0].at - hs_cyc), 128'(0));
    end
  endtask

  // One read: AR after ar_dly cycles, register data d cycles after REG_RDEN
  // (d = 0: never), RREADY held low for r_dly cycles once RVALID is up.
  task automatic rd_txn(input logic [31:0] addr, input logic [31:0] data, input int d,
                        input int ar_dly, input int r_dly);
    bit          legal, answered, done = 1'b0, hs;
    bit          rdy_bad = 1'b0, hold_bad = 1'b0;
    int          t = 0, hs_cyc = 0, exp_lat;
    logic [31:0] exp_data, d0;
    logic [1:0]  exp_resp, r0;
    legal    = (addr[31:16] == 16'h0);
    answered = legal && (d > 0) && (d <= RD_TO);
    exp_data = answered ? data : 32'h0;
    exp_resp = answered ? 2'b00 : 2'b10;
    exp_lat  = !legal ? 1 : (answered ? d + 1 : RD_TO + 1);
    rsp_delay = d;
    rsp_data  = data;
    rd_q.delete();
    S_AXI_RREADY = 1'b0;
    while (!done && t < 50) begin
      S_AXI_ARVALID = (t >= ar_dly);
      S_AXI_ARADDR  = S_AXI_ARVALID ? addr : $urandom;
      hs = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge CLK); #1;
      t++;
      if (hs) begin
        done   = 1'b1;
        hs_cyc = cyc;
      end
    end
    S_AXI_ARVALID = 1'b0;
    S_AXI_ARADDR  = $urandom;
    check("rd_handshake", 128'(done), 128'(1));
    if (!done) return;
    t = 0;
    while (S_AXI_RVALID !== 1'b1 && t < 40) begin
      if (S_AXI_ARREADY) rdy_bad = 1'b1;
      @(posedge CLK); #1;
      t++;
    end
    check("rd_rvalid_seen", 128'(S_AXI_RVALID), 128'(1));
    check("rd_latency", 128'(cyc - hs_cyc), 128'(exp_lat));
    check("rd_rdata", 128'(S_AXI_RDATA), 128'(exp_data));
    check("rd_rresp", 128'(S_AXI_RRESP), 128'(exp_resp));
    d0 = S_AXI_RDATA;
    r0 = S_AXI_RRESP;
    repeat (r_dly) begin
      @(posedge CLK); #1;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== d0 || S_AXI_RRESP !== r0) hold_bad = 1'b1;
      if (S_AXI_ARREADY) rdy_bad = 1'b1;
    end
    S_AXI_RREADY = 1'b1;
    @(posedge CLK); #1;
    S_AXI_RREADY = 1'b0;
    check("rd_r_hold", 128'(hold_bad), 128'(0));
    check("rd_ready_low", 128'(rdy_bad), 128'(0));
    check("rd_ready_back", 128'({S_AXI_RVALID, S_AXI_ARREADY}), 128'(2'b01));
    check("rd_rden_count", 128'(rd_q.size()), 128'(legal));
    if (legal && rd_q.size() > 0) begin
      check("rd_radr", 128'(rd_q[0].adr), 128'(addr[15:0]));
      check("rd_rden_latency", 128'(rd_q[0].at - hs_cyc), 128'(0));
    end
    t = 0;
    while (rsp_busy && t < 64) begin
      @(posedge CLK); #1;
      t++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] waddr, wdata, raddr, rdata;
    logic [3:0]  wstrb;
    int          kind, d;
    bit          quiet_bad;

    RST_N = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;

    // Reset state and first cycle after release.
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs_zero", 128'(all_outs()), 128'(0));
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check("reset_ready_first", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b111));

    // Directed writes: same cycle, W before AW with slow BREADY, illegal forms.
    wr_txn(32'h0000_0010, 32'hA5A5_5A5A, 4'hF, 0, 0, 0);
    wr_txn(32'h0000_0044, 32'hDEAD_BEEF, 4'hF, 3, 0, 4);
    wr_txn(32'h0000_0048, 32'h0102_0304, 4'hF, 0, 2, 1);
    wr_txn(32'h0001_0000, 32'h1111_2222, 4'hF, 0, 0, 0);
    wr_txn(32'h0000_0008, 32'h3333_4444, 4'h3, 1, 1, 2);

    // Directed reads: answered, timeout, late data, answer on the last wait
    // cycle, answer one cycle too late, out-of-range address.
    rd_txn(32'h0000_0020, 32'h1234_5678, 3, 0, 3);
    rd_txn(32'h0000_0030, 32'h5555_AAAA, 0, 0, 1);
    rd_txn(32'h0000_0030, 32'hFFFF_FFFF, RD_TO + 2, 0, 4);
    rd_txn(32'h0000_0034, 32'hCAFE_0008, RD_TO, 1, 0);
    rd_txn(32'h0000_0038, 32'hCAFE_0009, RD_TO + 1, 0, 0);
    rd_txn(32'h0002_0020, 32'h7777_7777, 2, 0, 1);

    // Concurrent write and read.
    fork
      wr_txn(32'h0000_0100, 32'h0BEE_F00D, 4'hF, 1, 2, 3);
      rd_txn(32'h0000_0200, 32'h0F0F_0F0F, 5, 0, 2);
    join

    // Reset during R_WAIT with a half-captured write pending.
    rsp_delay = 0;
    wr_q.delete();
    rd_q.delete();
    S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = 32'h0000_0040;
    S_AXI_ARVALID = 1'b1; S_AXI_ARADDR = 32'h0000_0030;
    @(posedge CLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("rst_pre_rden", 128'(rd_q.size()), 128'(1));
    RST_N = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("rst_mid_outputs_zero", 128'(all_outs()), 128'(0));
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check("rst_mid_ready_first", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b111));
    quiet_bad = 1'b0;
    rd_q.delete();
    repeat (2 * RD_TO) begin
      if (S_AXI_BVALID || S_AXI_RVALID || REG_WREN || REG_RDEN) quiet_bad = 1'b1;
      @(posedge CLK); #1;
    end
    check("rst_no_stale_activity", 128'({quiet_bad, 8'(wr_q.size()), 8'(rd_q.size())}), 128'(0));
    wr_txn(32'h0000_0050, 32'h600D_D47A, 4'hF, 0, 1, 0);
    rd_txn(32'h0000_0060, 32'h8765_4321, 2, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      kind  = $urandom_range(0, 2);
      waddr = {16'h0, 16'($urandom)};
      if ($urandom_range(0, 3) == 0) waddr[31:16] = 16'($urandom_range(1, 65535));
      wstrb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      wdata = $urandom;
      raddr = {16'h0, 16'($urandom)};
      if ($urandom_range(0, 3) == 0) raddr[31:16] = 16'($urandom_range(1, 65535));
      rdata = $urandom;
      d     = $urandom_range(0, RD_TO + 3);
      case (kind)
        0: wr_txn(waddr, wdata, wstrb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        1: rd_txn(raddr, rdata, d, $urandom_range(0, 3), $urandom_range(0, 3));
        default: begin
          fork
            wr_txn(waddr, wdata, wstrb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            rd_txn(raddr, rdata, d, $urandom_range(0, 3), $urandom_range(0, 3));
          join
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi4_lite_sif.md
AXI4_LITE_SIF -- requirements
Module: axi4_lite_sif

Interface
REQ-001 The block SHALL have one parameter: RD_TIMEOUT, default 16'd255, the number of cycles to wait for REG_RVLD after REG_RDEN before a read is errored.
REQ-002 The block SHALL use one clock, CLK; reset RST_N is synchronous and active-low.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
 CLK  in  1  clock
 RST_N  in  1  sync active-low reset
 S_AXI_AWADDR  in  32  write address
 S_AXI_AWVALID  in  1  write address valid
 S_AXI_AWREADY  out  1  write address ready
 S_AXI_WDATA  in  32  write data
 S_AXI_WSTRB  in  4  write byte strobes
 S_AXI_WVALID  in  1  write data valid
 S_AXI_WREADY  out  1  write data ready
 S_AXI_BRESP  out  2  write response
 S_AXI_BVALID  out  1  write response valid
 S_AXI_BREADY  in  1  write response ready
 S_AXI_ARADDR  in  32  read address
 S_AXI_ARVALID  in  1  read address valid
 S_AXI_ARREADY  out  1  read address ready
 S_AXI_RDATA  out  32  read data
 S_AXI_RRESP  out  2  read response
 S_AXI_RVALID  out  1  read data valid
 S_AXI_RREADY  in  1  read data ready
 REG_WREN  out  1  register write strobe (1-cycle pulse)
 REG_WADR  out  16  register write address
 REG_WDAT  out  32  register write data
 REG_RDEN  out  1  register read strobe (1-cycle pulse)
 REG_RADR  out  16  register read address
 REG_RDAT  in  32  register read data
 REG_RVLD  in  1  register read data valid

Function
REQ-004 The write and read channels SHALL run as independent FSMs and MAY be active concurrently; all outputs SHALL be registered.
REQ-005 Write FSM states SHALL be W_IDLE, W_ISSUE, W_RESP.
REQ-006 In W_IDLE: AWREADY=1 until the AW handshake, WREADY=1 until the W handshake; each handshake captures its payload and drops its READY the next cycle. AW and W may arrive in either order or in the same cycle.
REQ-007 With both captured, the FSM SHALL enter W_ISSUE for exactly one cycle.
REQ-008 A write is legal iff AWADDR[31:16]==0 and WSTRB==4'hF. In W_ISSUE, a legal write drives REG_WREN=1 with REG_WADR=AWADDR[15:0] and REG_WDAT=WDATA. An illegal write drives no REG_WREN.
REQ-009 On entering W_RESP: BVALID=1, BRESP=2'b00 if legal, else 2'b10 (SLVERR). BVALID and BRESP SHALL hold until BREADY=1, then return to W_IDLE with AWREADY and WREADY reasserted the following cycle.
REQ-010 Read FSM states SHALL be R_IDLE, R_ISSUE, R_WAIT, R_RESP.
REQ-011 R_IDLE: ARREADY=1; the AR handshake captures ARADDR, drops ARREADY the next cycle, and enters R_ISSUE.
REQ-012 R_ISSUE (one cycle):
 - ARADDR[31:16]==0: REG_RDEN=1, REG_RADR=ARADDR[15:0]; go to R_WAIT.
 - Otherwise: no REG_RDEN; go to R_RESP with RDATA=0 and RRESP=2'b10.
REQ-013 R_WAIT SHALL count cycles from 0. When REG_RVLD=1, latch REG_RDAT into RDATA with RRESP=2'b00 and go to R_RESP. If the count reaches RD_TIMEOUT first, set RDATA=0 and RRESP=2'b10 and go to R_RESP.
REQ-014 R_RESP: RVALID=1; RDATA and RRESP SHALL hold until RREADY=1, then return to R_IDLE.
REQ-015 REG_RVLD outside R_WAIT SHALL be ignored.
REQ-016 AXI input changes while VALID=0 SHALL have no effect.
REQ-017 Minimum latency: AW/W handshake to REG_WREN = 1 cycle; AR handshake to REG_RDEN = 1 cycle.

Reset
REQ-018 While RST_N=0, every output SHALL be 0 (READYs, VALIDs, RESPs, RDATA, REG_* outputs), both FSMs SHALL be in IDLE, and the counter SHALL be 0.
REQ-019 AWREADY, WREADY and ARREADY SHALL assert on the first cycle after RST_N rises.
REQ-020 Reset asserted mid-transaction SHALL discard all captured state with no pending REG pulse or response issued after release.

Verification
REQ-021 AW(0x0000_0010) and W(0xA5A5_5A5A, strb F) in the same cycle, BREADY=1 -> one REG_WREN pulse, WADR=0x0010, WDAT=0xA5A5_5A5A; BVALID with BRESP=00 one cycle later.
REQ-022 W first, AW 3 cycles later, BREADY held low 4 cycles -> REG_WREN pulses once only after AW; BVALID held for 4 cycles; AWREADY/WREADY return after BREADY.
REQ-023 AW 0x0001_0000 or WSTRB=4'h3 -> no REG_WREN; BRESP=2'b10.
REQ-024 AR 0x0020, REG_RVLD 3 cycles after REG_RDEN with 0x1234_5678 -> RVALID, RDATA=0x1234_5678, RRESP=00; RDATA held while RREADY is low.
REQ-025 AR 0x0030, no REG_RVLD, RD_TIMEOUT=8 -> RVALID after 8 wait cycles with RDATA=0 and RRESP=2'b10; a late REG_RVLD is ignored.
REQ-026 Concurrent write and read, and RST_N pulsed low during R_WAIT -> both channels complete independently; after the reset, all outputs are 0 and ARREADY=1 on the first cycle after release.
